bbus_master: RTL

//  Parametrised SNES B-bus master; the active successor to the idle bus tie-off.

---
 rtl/bbus_master_pkg.sv | 19 +
 rtl/bbus_master.sv | 105 ++++++++++
 2 files changed

// File: rtl/bbus_master_pkg.sv
// bbus_master_pkg: shared B-bus direction encodings, FSM states and timing-counter helper
package bbus_master_pkg;
  localparam logic LVL_DIR_INPUT  = 1'b0;
  localparam logic LVL_DIR_OUTPUT = 1'b1;
  localparam logic DIR_INPUT      = 1'b0;
  localparam logic DIR_OUTPUT     = 1'b1;
  localparam int   BBUS_CNT_W     = 8;
  typedef enum logic [2:0] {
    BBUS_ST_IDLE,
    BBUS_ST_LVL_ON,
    BBUS_ST_SETUP,
    BBUS_ST_STROBE,
    BBUS_ST_HOLD,
    BBUS_ST_DRV_OFF
  } bbus_state_e;
  function automatic logic [BBUS_CNT_W-1:0] bbus_load(input int cycles);
    return BBUS_CNT_W'(cycles - 1);
  endfunction
endpackage

// File: rtl/bbus_master.sv
// bbus_master: SNES B-bus master turning single-beat requests into timed PARD/PAWR cycles; BBUS_MASTER_STATS_EN enables txn_count
module bbus_master
  import bbus_master_pkg::*;
#(
  parameter int TURN_CYCLES   = 1,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] txn_count,
  output logic        pard_n,
  output logic        pawr_n,
  output logic        lvl_pa_dir,
  output logic        lvl_pd_dir,
  input  logic [7:0]  pa_in,
  output logic [7:0]  pa_out,
  output logic        pa_dir,
  input  logic [7:0]  pd_in,
  output logic [7:0]  pd_out,
  output logic        pd_dir
);
  bbus_state_e state, state_nx;
  logic [BBUS_CNT_W-1:0] cnt, cnt_nx;
  logic [7:0] addr_q, wdata_q, rdata_q;
  logic wr_q, hs, done, wr_nx, drive, rsp_nx;
  logic unused_pa;
  assign unused_pa = ^pa_in;
  assign hs = req_valid && req_ready;
  assign done = cnt == '0;
  assign wr_nx = hs ? req_write : wr_q;
  // next state; the single timing counter reloads on every state entry
  always_comb begin
    state_nx = state;
    cnt_nx = done ? cnt : cnt - 1'b1;
    case (state)
      BBUS_ST_IDLE:    if (hs)   begin state_nx = BBUS_ST_LVL_ON;  cnt_nx = bbus_load(TURN_CYCLES);   end
      BBUS_ST_LVL_ON:  if (done) begin state_nx = BBUS_ST_SETUP;   cnt_nx = bbus_load(SETUP_CYCLES);  end
      BBUS_ST_SETUP:   if (done) begin state_nx = BBUS_ST_STROBE;  cnt_nx = bbus_load(STROBE_CYCLES); end
      BBUS_ST_STROBE:  if (done) begin state_nx = BBUS_ST_HOLD;    cnt_nx = bbus_load(HOLD_CYCLES);   end
      BBUS_ST_HOLD:    if (done) begin state_nx = BBUS_ST_DRV_OFF; cnt_nx = bbus_load(TURN_CYCLES);   end
      BBUS_ST_DRV_OFF: if (done) state_nx = BBUS_ST_IDLE;
      default:         state_nx = BBUS_ST_IDLE;
    endcase
  end
  assign drive = state_nx inside {BBUS_ST_SETUP, BBUS_ST_STROBE, BBUS_ST_HOLD};
  assign rsp_nx = state == BBUS_ST_HOLD && state_nx == BBUS_ST_DRV_OFF;
  // state, captured request and all pad/response outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BBUS_ST_IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      pard_n     <= 1'b1;
      pawr_n     <= 1'b1;
      lvl_pa_dir <= LVL_DIR_INPUT;
      lvl_pd_dir <= LVL_DIR_INPUT;
      pa_dir     <= DIR_INPUT;
      pd_dir     <= DIR_INPUT;
      pa_out     <= '0;
      pd_out     <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      wr_q       <= wr_nx;
      addr_q     <= hs ? req_addr : addr_q;
      wdata_q    <= hs ? req_wdata : wdata_q;
      rdata_q    <= (state == BBUS_ST_STROBE && done && !wr_q) ? pd_in : rdata_q;
      req_ready  <= state_nx == BBUS_ST_IDLE;
      rsp_valid  <= rsp_nx;
      rsp_rdata  <= (rsp_nx && !wr_q) ? rdata_q : '0;
      pard_n     <= !(state_nx == BBUS_ST_STROBE && !wr_q);
      pawr_n     <= !(state_nx == BBUS_ST_STROBE && wr_q);
      lvl_pa_dir <= state_nx != BBUS_ST_IDLE ? LVL_DIR_OUTPUT : LVL_DIR_INPUT;
      lvl_pd_dir <= (state_nx != BBUS_ST_IDLE && wr_nx) ? LVL_DIR_OUTPUT : LVL_DIR_INPUT;
      pa_dir     <= drive ? DIR_OUTPUT : DIR_INPUT;
      pd_dir     <= (drive && wr_q) ? DIR_OUTPUT : DIR_INPUT;
      pa_out     <= drive ? addr_q : '0;
      pd_out     <= (drive && wr_q) ? wdata_q : '0;
    end
  end
`ifdef BBUS_MASTER_STATS_EN
  // completed-transaction counter, wraps at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) txn_count <= '0;
    else if (rsp_valid) txn_count <= txn_count + 16'd1;
  end
`else
  assign txn_count = '0;
`endif
endmodule
